// File: rtl/param_seq_divider.sv
// param_seq_divider: multi-cycle restoring divider, one quotient bit per clock.
//
// Optional feature macro: SIGNED_DIV_EN. When it is defined, the signed_i port
// and the FIX state exist. Without it the unit is unsigned only.
//
// Parameters:
//   N   operand/result width (N >= 2)
//   CW  iteration counter width, derived from N
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-high reset
//   start_i     request; sampled only in IDLE, held high until done_o is seen
//   data_a_i    dividend, captured on the edge that accepts start_i
//   data_b_i    divisor, captured on the same edge
//   signed_i    two's-complement operation select (SIGNED_DIV_EN only)
//   q_o         quotient register
//   r_o         remainder register
//   done_o      result valid (DONE state)
//   div_zero_o  last operation had a zero divisor
//   busy_o      high in CALC/FIX
module param_seq_divider #(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] data_a_i,
    input  logic [N-1:0] data_b_i,
`ifdef SIGNED_DIV_EN
    input  logic         signed_i,
`endif
    output logic [N-1:0] q_o,
    output logic [N-1:0] r_o,
    output logic         done_o,
    output logic         div_zero_o,
    output logic         busy_o
);

    localparam int unsigned CW = $clog2(N + 1);

`ifdef SIGNED_DIV_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2,
        StFix  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;
`endif

    state_e        state_q;
    logic [N-1:0]  a_q;      // dividend, shifts out MSB-first, collects quotient bits
    logic [N-1:0]  b_q;      // divisor magnitude
    logic [N-1:0]  p_q;      // partial remainder
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  q_q;
    logic [N-1:0]  r_q;
    logic          dz_q;

    logic [N-1:0]  a_mag_w;
    logic [N-1:0]  b_mag_w;
    logic [N:0]    shift_w;
    logic [N:0]    trial_w;
    logic          borrow_w;
    logic [N-1:0]  a_next_w;

`ifdef SIGNED_DIV_EN
    logic sgn_q;   // operation runs through FIX
    logic qneg_q;  // operand signs differ
    logic rneg_q;  // dividend negative

    // Magnitudes of the operands; -2^(N-1) maps to 2^(N-1), which is still
    // representable as an unsigned N-bit value.
    assign a_mag_w = (signed_i && data_a_i[N-1]) ? -data_a_i : data_a_i;
    assign b_mag_w = (signed_i && data_b_i[N-1]) ? -data_b_i : data_b_i;
`else
    assign a_mag_w = data_a_i;
    assign b_mag_w = data_b_i;
`endif

    // P < B holds every step, so the shifted value is below 2B and any
    // non-negative trial fits N bits. Bit N of the N+1-bit difference is
    // therefore exactly the borrow.
    assign shift_w  = {p_q, a_q[N-1]};
    assign trial_w  = shift_w - {1'b0, b_q};
    assign borrow_w = trial_w[N];
    assign a_next_w = {a_q[N-2:0], ~borrow_w};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (data_b_i == '0) begin
                            q_q     <= '1;
                            r_q     <= data_a_i;
                            dz_q    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            a_q     <= a_mag_w;
                            b_q     <= b_mag_w;
                            p_q     <= '0;
                            cnt_q   <= CW'(N);
                            dz_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
                            sgn_q   <= signed_i;
                            qneg_q  <= signed_i && (data_a_i[N-1] ^ data_b_i[N-1]);
                            rneg_q  <= signed_i && data_a_i[N-1];
`endif
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    a_q   <= a_next_w;
                    p_q   <= borrow_w ? shift_w[N-1:0] : trial_w[N-1:0];
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        q_q <= a_next_w;
                        r_q <= borrow_w ? shift_w[N-1:0] : trial_w[N-1:0];
`ifdef SIGNED_DIV_EN
                        state_q <= sgn_q ? StFix : StDone;
`else
                        state_q <= StDone;
`endif
                    end
                end
`ifdef SIGNED_DIV_EN
                StFix: begin
                    // Overflow case needs no special handling: |Q| = 2^(N-1)
                    // with equal signs is left unnegated, which is -2^(N-1).
                    q_q     <= qneg_q ? -q_q : q_q;
                    r_q     <= rneg_q ? -r_q : r_q;
                    state_q <= StDone;
                end
`endif
                StDone: begin
                    if (!start_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign q_o        = q_q;
    assign r_o        = r_q;
    assign div_zero_o = dz_q;
    assign done_o     = (state_q == StDone);
`ifdef SIGNED_DIV_EN
    assign busy_o     = (state_q == StCalc) || (state_q == StFix);
`else
    assign busy_o     = (state_q == StCalc);
`endif

endmodule

// File: doc/param_seq_divider.md
Name: param_seq_divider

Overview:
- Parametrised successor to the team's 8-bit shift/subtract divider.
- N-bit dividend/divisor, one quotient bit per clock, start/done handshake, explicit divide-by-zero detection.
- Optional signed mode.
- Sits as a multi-cycle arithmetic unit beside datapath registers; the controller drives Start and waits on Done.

Parameters:
- N, 8, operand/result width in bits (N >= 2)
- CW, $clog2(N+1), iteration counter width (derived, not overridden)

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request; sampled only in IDLE; level-held by controller until Done seen
- DataA  input  N  dividend, captured on the edge that accepts Start
- DataB  input  N  divisor, captured on the same edge
- Signed  input  1  signed-operation select; present only with SIGNED_DIV_EN, captured with operands
- Q  output  N  quotient register
- R  output  N  remainder register
- Done  output  1  result valid
- DivZero  output  1  last operation had divisor 0
- Busy  output  1  high in CALC/FIX

Behaviour:
- One clock (Clock); reset is asynchronous and active-high (Reset).
- Reset, asynchronous, any state: state=IDLE; Q, R, counter, internal A/B/partial-remainder = 0; Done = Busy = DivZero = 0.
- States: IDLE, CALC, FIX (SIGNED_DIV_EN only), DONE. All outputs registered or decoded from state only.
- IDLE:
  - Start=0: stay; Q/R/DivZero keep the previous result.
  - Start=1, DataB != 0: latch operands; partial remainder=0; counter=N; DivZero<=0; go to CALC.
  - Start=1, DataB == 0: Q <= all ones; R <= DataA; DivZero <= 1; go to DONE directly. Done is high after that single edge.
- CALC, per edge:
  - shift {P, A} left by 1.
  - trial = P_shifted - B, computed N+1 bits wide.
  - No borrow: P <= trial and quotient LSB <= 1. Borrow: P restored and LSB <= 0.
  - Decrement counter. On the edge where counter goes 1 -> 0: load Q and R, go to DONE (or to FIX).
- Latency, unsigned nonzero divisor: Done high exactly N cycles after the Start-capturing edge. Signed: N+1.
- DONE: Done=1; Q/R/DivZero stable.
  - Start=1: stay in DONE.
  - Start=0: go to IDLE next edge; Done drops.
  - A new operation therefore needs Start low for at least one cycle.
- Start, DataA and DataB are ignored outside IDLE; operand changes mid-operation have no effect.
- Reset mid-CALC aborts immediately; no partial result is visible.
- Invariant for nonzero B (unsigned): A == Q*B + R and R < B.
- Widths: all arithmetic at N+1 bits internally; no truncation before the borrow test.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined: Signed port exists.
  - Signed=1: operands are two's complement. Magnitudes are divided in CALC; FIX (one extra cycle) negates Q if the operand signs differ and negates R if the dividend is negative.
  - Quotient truncates toward zero; R takes the dividend's sign.
  - Overflow (-2^(N-1) / -1): Q = -2^(N-1), R = 0, DivZero = 0.
  - Divide by zero in signed mode: Q = all ones, R = DataA.
  - Signed=0: identical to the undefined build, including FIX being skipped.
- Undefined: no Signed port, no FIX state; unsigned only.

Test Plan:
- N=8, A=30, B=5, Start held until Done: Done rises 8 cycles after the capture edge; Q=6, R=0, DivZero=0, Busy=0 in DONE.
- A=255, B=16 -> Q=15, R=15. Then A=3, B=200 -> Q=0, R=3. Start dropped between the two operations; Done falls one cycle after Start drops.
- A=7, B=0 -> Done high one cycle after capture; DivZero=1, Q=8'hFF, R=7. Next operation A=9, B=3 clears DivZero, giving Q=3, R=0.
- Reset pulsed at cycle 4 of CALC (A=100, B=7): all outputs 0 asynchronously, state IDLE. A fresh A=100, B=7 run gives Q=14, R=2.
- DataA/DataB toggled randomly during CALC, and Start held high through DONE for 5 cycles: result unchanged, Done stays high, no re-trigger.
- SIGNED_DIV_EN, Signed=1:
  - -7/2 -> Q=8'hFD, R=8'hFF after 9 cycles.
  - 7/-2 -> Q=8'hFD, R=1.
  - -128/-1 -> Q=8'h80, R=0.
